object_pattern_streamer: RTL and testbench

// - Transmitter side of the object-spawn handshake: walks a stage pattern table and hands object descriptors
//   to multi-object collider/runtime blocks via sync_object_position / update_object_position.
// - Each table entry waits its own delay in centisecond ticks, then is presented and held until the runtime acks.

---
 rtl/object_pattern_streamer_if.sv | 58 +++++
 rtl/object_pattern_streamer.sv | 168 ++++++++++++++++
 tb/tb_object_pattern_streamer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/object_pattern_streamer_if.sv
// ---------------------------------------------------------------------------
// object_pattern_streamer_if
//
// Purpose: carries one object descriptor from the pattern streamer to the
// collider/runtime blocks, together with the four-phase spawn handshake.
//
// Signals:
//   object_movement_direction  3   movement direction code
//   object_pos_x / object_pos_y 10  spawn position
//   object_w / object_h        10  object size
//   object_speed               5   speed code
//   object_destroy_time        8   lifetime
//   object_destroy_trigger     2   destroy condition code
//   sync_object_position       1   active-low "descriptor valid" (1 = idle)
//   update_object_position     1   runtime ack, high = descriptor captured
//
// Modports:
//   master - the streamer (drives descriptor and sync, receives ack)
//   slave  - a runtime consumer (receives descriptor and sync, drives ack)
// ---------------------------------------------------------------------------
interface object_pattern_streamer_if;
    logic [2:0] object_movement_direction;
    logic [9:0] object_pos_x;
    logic [9:0] object_pos_y;
    logic [9:0] object_w;
    logic [9:0] object_h;
    logic [4:0] object_speed;
    logic [7:0] object_destroy_time;
    logic [1:0] object_destroy_trigger;
    logic       sync_object_position;
    logic       update_object_position;

    modport master (
        output object_movement_direction,
        output object_pos_x,
        output object_pos_y,
        output object_w,
        output object_h,
        output object_speed,
        output object_destroy_time,
        output object_destroy_trigger,
        output sync_object_position,
        input  update_object_position
    );

    modport slave (
        input  object_movement_direction,
        input  object_pos_x,
        input  object_pos_y,
        input  object_w,
        input  object_h,
        input  object_speed,
        input  object_destroy_time,
        input  object_destroy_trigger,
        input  sync_object_position,
        output update_object_position
    );
endinterface

// File: rtl/object_pattern_streamer.sv
// ---------------------------------------------------------------------------
// object_pattern_streamer
//
// Purpose: transmitter side of the object-spawn handshake. Walks a stage
// pattern table entry by entry; each entry waits its own delay (counted in
// centisecond ticks), is then presented on object_bus with
// sync_object_position low, and is held until the runtime acknowledges it
// with a full four-phase handshake.
//
// Parameters:
//   PATTERN_LEN  number of table entries (2..1024), last index PATTERN_LEN-1
//   ADDR_W       width of pattern_addr, 2**ADDR_W >= PATTERN_LEN
//
// Ports:
//   clk_calculation    in   sole clock, everything on the rising edge
//   reset              in   synchronous active-high reset
//   is_reset_stage     in   synchronous stage restart, same effect as reset
//   start              in   1-cycle pulse, starts from entry 0 when IDLE/DONE
//   tick_centi_second  in   1-cycle enable every 10 ms
//   pattern_addr       out  table read address
//   pattern_data       in   table word, valid one cycle after pattern_addr
//   object_bus         master side of object_pattern_streamer_if
//   stream_busy        out  high in every state other than IDLE/DONE
//   stream_done        out  high in DONE
//
// Table word layout [65:0]:
//   delay[65:58] dir[57:55] x[54:45] y[44:35] w[34:25] h[24:15]
//   speed[14:10] destroy_time[9:2] trigger[1:0]
//
// Configuration macro:
//   OBJECT_STREAM_LOOP_EN  when defined, the stream wraps from the last entry
//                          back to entry 0 forever and DONE is never reached.
// ---------------------------------------------------------------------------
module object_pattern_streamer #(
    parameter int PATTERN_LEN = 16,
    parameter int ADDR_W      = 10
) (
    input  logic                      clk_calculation,
    input  logic                      reset,
    input  logic                      is_reset_stage,
    input  logic                      start,
    input  logic                      tick_centi_second,
    output logic [ADDR_W-1:0]         pattern_addr,
    input  logic [65:0]               pattern_data,
    object_pattern_streamer_if.master object_bus,
    output logic                      stream_busy,
    output logic                      stream_done
);

    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(PATTERN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_DELAY,
        S_PRESENT,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t     state;
    logic [7:0] delay_count;
    logic       ack_low_seen;

    // pattern_addr doubles as the entry index: it is only ever changed on the
    // way into FETCH, so the table word arriving in LOAD always belongs to
    // the entry being processed.
    //
    // ack_low_seen guards against a stale ack: the runtime may still hold
    // update_object_position high from an earlier transfer when a new
    // descriptor is presented. The ack is only honoured once it has been
    // observed low at or after the edge that presented the descriptor.
    always_ff @(posedge clk_calculation) begin
        if (reset || is_reset_stage) begin
            state                                <= S_IDLE;
            pattern_addr                         <= '0;
            delay_count                          <= '0;
            ack_low_seen                         <= 1'b0;
            object_bus.object_movement_direction <= '0;
            object_bus.object_pos_x              <= '0;
            object_bus.object_pos_y              <= '0;
            object_bus.object_w                  <= '0;
            object_bus.object_h                  <= '0;
            object_bus.object_speed              <= '0;
            object_bus.object_destroy_time       <= '0;
            object_bus.object_destroy_trigger    <= '0;
            object_bus.sync_object_position      <= 1'b1;
            stream_busy                          <= 1'b0;
            stream_done                          <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pattern_addr <= '0;
                        state        <= S_FETCH;
                        stream_busy  <= 1'b1;
                        stream_done  <= 1'b0;
                    end
                end

                // Address is already on the bus; give the table one cycle.
                S_FETCH: begin
                    state <= S_LOAD;
                end

                S_LOAD: begin
                    delay_count                          <= pattern_data[65:58];
                    object_bus.object_movement_direction <= pattern_data[57:55];
                    object_bus.object_pos_x              <= pattern_data[54:45];
                    object_bus.object_pos_y              <= pattern_data[44:35];
                    object_bus.object_w                  <= pattern_data[34:25];
                    object_bus.object_h                  <= pattern_data[24:15];
                    object_bus.object_speed              <= pattern_data[14:10];
                    object_bus.object_destroy_time       <= pattern_data[9:2];
                    object_bus.object_destroy_trigger    <= pattern_data[1:0];
                    state                                <= S_DELAY;
                end

                // A zero count leaves without consuming a tick, so a tick on
                // the same edge is simply dropped.
                S_DELAY: begin
                    if (delay_count == 8'd0) begin
                        state                           <= S_PRESENT;
                        object_bus.sync_object_position <= 1'b0;
                        ack_low_seen                    <= !object_bus.update_object_position;
                    end else if (tick_centi_second) begin
                        delay_count <= delay_count - 8'd1;
                    end
                end

                S_PRESENT: begin
                    if (!object_bus.update_object_position) begin
                        ack_low_seen <= 1'b1;
                    end else if (ack_low_seen) begin
                        state                           <= S_RELEASE;
                        object_bus.sync_object_position <= 1'b1;
                    end
                end

                // Four-phase: the next entry is not fetched until the
                // runtime has dropped its ack.
                S_RELEASE: begin
                    if (!object_bus.update_object_position) begin
                        if (pattern_addr == LAST_INDEX) begin
`ifdef OBJECT_STREAM_LOOP_EN
                            pattern_addr <= '0;
                            state        <= S_FETCH;
`else
                            state        <= S_DONE;
                            stream_busy  <= 1'b0;
                            stream_done  <= 1'b1;
`endif
                        end else begin
                            pattern_addr <= pattern_addr + ADDR_W'(1);
                            state        <= S_FETCH;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_object_pattern_streamer.sv
// ---------------------------------------------------------------------------
// tb_object_pattern_streamer
//
// Purpose: self-checking bench for object_pattern_streamer. A transaction-
// level model predicts, from edge arithmetic on the table and the sampled
// inputs, which entry is presented, when sync_object_position falls and
// which descriptor fields must be visible; one compare process checks the
// DUT against it every cycle. Directed sections pin the model with
// hand-computed literals (first presentation latency, tick counting, ack
// hold, handshake count, address order, stale ack, mid-transfer restart).
//
// Build with OBJECT_STREAM_LOOP_EN defined to exercise the wrapping stream.
// ---------------------------------------------------------------------------
module tb_object_pattern_streamer;

`ifdef OBJECT_STREAM_LOOP_EN
    localparam int LEN = 3;
`else
    localparam int LEN = 4;
`endif
    localparam int AW = 10;

    typedef struct {
        int delay;
        int dir;
        int x;
        int y;
        int w;
        int h;
        int speed;
        int dtime;
        int trig;
    } entry_t;

    typedef enum {M_IDLE, M_WAIT, M_PRES, M_REL, M_DONE} phase_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          is_reset_stage = 1'b0;
    logic          start = 1'b0;
    logic          tick = 1'b0;
    logic [AW-1:0] pattern_addr;
    logic [65:0]   pattern_data;
    logic          stream_busy;
    logic          stream_done;

    logic [65:0]   rom [LEN];
    entry_t        table_e [LEN];

    int total = 0;
    int bad = 0;

    bit auto_ack = 1'b0;
    bit auto_tick = 1'b0;
    bit model_on = 1'b0;

    int hs_log[$];

    object_pattern_streamer_if bus ();

    object_pattern_streamer #(
        .PATTERN_LEN(LEN),
        .ADDR_W     (AW)
    ) dut (
        .clk_calculation  (clk),
        .reset            (reset),
        .is_reset_stage   (is_reset_stage),
        .start            (start),
        .tick_centi_second(tick),
        .pattern_addr     (pattern_addr),
        .pattern_data     (pattern_data),
        .object_bus       (bus),
        .stream_busy      (stream_busy),
        .stream_done      (stream_done)
    );

    initial forever #5 clk = ~clk;

    // Synchronous table: word appears one cycle after the address.
    always @(posedge clk) begin
        if (pattern_addr < AW'(LEN)) pattern_data <= rom[int'(pattern_addr)];
        else pattern_data <= '0;
    end

    function automatic logic [65:0] pack_entry(input entry_t e);
        pack_entry = {8'(e.delay), 3'(e.dir), 10'(e.x), 10'(e.y), 10'(e.w),
                      10'(e.h), 5'(e.speed), 8'(e.dtime), 2'(e.trig)};
    endfunction

    function automatic entry_t make_e(input int d, dr, x, y, w, h, sp, dt, tr);
        entry_t e;
        e.delay = d; e.dir = dr; e.x = x; e.y = y; e.w = w; e.h = h;
        e.speed = sp; e.dtime = dt; e.trig = tr;
        return e;
    endfunction

    task automatic load_rom();
        for (int i = 0; i < LEN; i++) rom[i] = pack_entry(table_e[i]);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model and per-cycle compare.
    // An entry whose fetch starts at edge F has its fields latched at F+2;
    // from F+3 on it is presented at the first edge where the ticks seen
    // since F+3 equal its delay. An ack is honoured only after it has been
    // seen low from the presenting edge onward; the next fetch starts at the
    // first edge where the ack is seen low again.
    // ---------------------------------------------------------------------
    phase_t m_phase = M_IDLE;
    int     m_index = 0;
    int     m_fetch = 0;
    int     m_ticks = 0;
    bit     m_seen_low = 1'b0;
    entry_t m_entry = '{default: 0};
    int     cyc = 0;
    logic   prev_sync = 1'b1;

    always @(posedge clk) begin
        logic rst_s, start_s, tick_s, ack_s;
        bit   exp_busy;
        rst_s   = reset | is_reset_stage;
        start_s = start;
        tick_s  = tick;
        ack_s   = bus.update_object_position;
        cyc++;
        if (rst_s) begin
            m_phase = M_IDLE;
            m_index = 0;
            m_entry = '{default: 0};
        end else begin
            case (m_phase)
                M_IDLE, M_DONE: begin
                    if (start_s) begin
                        m_phase = M_WAIT;
                        m_index = 0;
                        m_fetch = cyc;
                        m_ticks = 0;
                    end
                end
                M_WAIT: begin
                    if (cyc == m_fetch + 2) begin
                        m_entry = table_e[m_index];
                    end else if (cyc >= m_fetch + 3) begin
                        if (m_ticks == m_entry.delay) begin
                            m_phase    = M_PRES;
                            m_seen_low = !ack_s;
                        end else if (tick_s) begin
                            m_ticks++;
                        end
                    end
                end
                M_PRES: begin
                    if (!ack_s) m_seen_low = 1'b1;
                    else if (m_seen_low) m_phase = M_REL;
                end
                M_REL: begin
                    if (!ack_s) begin
                        if (m_index == LEN - 1) begin
`ifdef OBJECT_STREAM_LOOP_EN
                            m_index = 0;
                            m_fetch = cyc;
                            m_ticks = 0;
                            m_phase = M_WAIT;
`else
                            m_phase = M_DONE;
`endif
                        end else begin
                            m_index++;
                            m_fetch = cyc;
                            m_ticks = 0;
                            m_phase = M_WAIT;
                        end
                    end
                end
                default: m_phase = M_IDLE;
            endcase
        end
        #1;
        if (model_on) begin
            exp_busy = (m_phase == M_WAIT) || (m_phase == M_PRES) || (m_phase == M_REL);
            check_output("model sync", bus.sync_object_position, (m_phase == M_PRES) ? 0 : 1);
            check_output("model busy", stream_busy, exp_busy);
            check_output("model done", stream_done, (m_phase == M_DONE) ? 1 : 0);
            check_output("model addr", pattern_addr, m_index);
            check_output("model dir", bus.object_movement_direction, m_entry.dir);
            check_output("model x", bus.object_pos_x, m_entry.x);
            check_output("model y", bus.object_pos_y, m_entry.y);
            check_output("model w", bus.object_w, m_entry.w);
            check_output("model h", bus.object_h, m_entry.h);
            check_output("model speed", bus.object_speed, m_entry.speed);
            check_output("model dtime", bus.object_destroy_time, m_entry.dtime);
            check_output("model trig", bus.object_destroy_trigger, m_entry.trig);
        end
        if (prev_sync === 1'b1 && bus.sync_object_position === 1'b0)
            hs_log.push_back(int'(pattern_addr));
        prev_sync = bus.sync_object_position;
    end

    // One clock of stimulus; returns at the falling edge so callers can
    // override any input right after.
    task automatic apply_stimulus();
        @(negedge clk);
        if (auto_tick) tick = ($urandom_range(0, 3) == 0);
        if (auto_ack) begin
            if (!bus.sync_object_position && !bus.update_object_position) begin
                if ($urandom_range(0, 2) == 0) bus.update_object_position = 1'b1;
            end else if (bus.sync_object_position && bus.update_object_position) begin
                if ($urandom_range(0, 2) == 0) bus.update_object_position = 1'b0;
            end
        end
    endtask

    task automatic pulse_start();
        apply_stimulus();
        start = 1'b1;
        apply_stimulus();
        start = 1'b0;
    endtask

    task automatic pulse_stage_reset();
        apply_stimulus();
        is_reset_stage = 1'b1;
        apply_stimulus();
        is_reset_stage = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (stream_done !== 1'b1 && n < budget) begin
            apply_stimulus();
            n++;
        end
        check_output("done within budget", stream_done, 1);
    endtask

    task automatic wait_log(input int target, input int budget);
        int n = 0;
        while (hs_log.size() < target && n < budget) begin
            apply_stimulus();
            n++;
        end
        check_output("handshakes within budget", (hs_log.size() >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_sync_low(input int budget);
        int n = 0;
        while (bus.sync_object_position !== 1'b0 && n < budget) begin
            apply_stimulus();
            n++;
        end
        check_output("present within budget", bus.sync_object_position, 0);
    endtask

    initial begin
        int first_low;
        int base;
        bus.update_object_position = 1'b0;

        table_e[0] = make_e(0, 5, 100, 200, 16, 24, 7, 50, 1);
        table_e[1] = make_e(3, 2, 300, 40, 8, 8, 31, 255, 3);
        table_e[2] = make_e(0, 7, 1023, 1023, 1023, 1023, 0, 0, 2);
        if (LEN > 3) table_e[LEN-1] = make_e(1, 1, 5, 6, 7, 8, 9, 10, 0);
        load_rom();

        // Reset
        apply_stimulus();
        model_on = 1'b1;
        repeat (2) apply_stimulus();
        reset = 1'b0;
        @(posedge clk); #1;
        check_output("reset sync", bus.sync_object_position, 1);
        check_output("reset addr", pattern_addr, 0);
        check_output("reset busy", stream_busy, 0);
        check_output("reset done", stream_done, 0);
        check_output("reset x", bus.object_pos_x, 0);

        // Entry 0, delay 0: presented on the third edge after start is taken
        pulse_start();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_output("sync still high before present", bus.sync_object_position, 1);
        @(posedge clk); #1;
        check_output("entry0 sync low", bus.sync_object_position, 0);
        check_output("entry0 x", bus.object_pos_x, 100);
        check_output("entry0 y", bus.object_pos_y, 200);
        check_output("entry0 dir", bus.object_movement_direction, 5);
        apply_stimulus();
        bus.update_object_position = 1'b1;
        @(posedge clk); #1;
        check_output("ack raises sync", bus.sync_object_position, 1);

        // Runtime keeps its ack high for 5 cycles: no fetch of entry 1 yet
        repeat (5) begin
            @(posedge clk); #1;
            check_output("addr held while ack high", pattern_addr, 0);
            check_output("busy while ack high", stream_busy, 1);
        end
        apply_stimulus();
        bus.update_object_position = 1'b0;
        @(posedge clk); #1;
        check_output("addr advanced by one", pattern_addr, 1);

        // Entry 1, delay 3: ticks during FETCH/LOAD are ignored, then three
        // counted ticks at F+5/F+7/F+9 lead to presentation at F+10
        first_low = 0;
        for (int k = 1; k <= 12; k++) begin
            apply_stimulus();
            tick = (k == 1) || (k == 2) || (k == 5) || (k == 7) || (k == 9);
            @(posedge clk); #1;
            if (first_low == 0 && bus.sync_object_position === 1'b0) first_low = k;
        end
        apply_stimulus();
        tick = 1'b0;
        check_output("delay3 present edge", first_low, 10);
        check_output("entry1 x", bus.object_pos_x, 300);

        auto_ack = 1'b1;
        auto_tick = 1'b1;
`ifdef OBJECT_STREAM_LOOP_EN
        wait_log(5, 2000);
        for (int i = 0; i < 5; i++) check_output("loop address order", hs_log[i], i % 3);
        check_output("loop never done", stream_done, 0);
        check_output("loop still busy", stream_busy, 1);
`else
        wait_done(2000);
        check_output("handshake count run1", hs_log.size(), 4);
        for (int i = 0; i < 4; i++) check_output("run1 address order", hs_log[i], i);
        repeat (10) apply_stimulus();
        check_output("done holds sync high", bus.sync_object_position, 1);
        check_output("done holds last x", bus.object_pos_x, 5);
        pulse_start();
        wait_done(2000);
        check_output("handshake count run2", hs_log.size(), 8);
`endif

        // Randomised tables and handshake timing
        for (int r = 0; r < 3; r++) begin
            pulse_stage_reset();
            for (int i = 0; i < LEN; i++)
                table_e[i] = make_e($urandom_range(0, 3), $urandom_range(0, 7),
                                    $urandom_range(0, 1023), $urandom_range(0, 1023),
                                    $urandom_range(0, 1023), $urandom_range(0, 1023),
                                    $urandom_range(0, 31), $urandom_range(0, 255),
                                    $urandom_range(0, 3));
            load_rom();
            base = hs_log.size();
            pulse_start();
`ifdef OBJECT_STREAM_LOOP_EN
            wait_log(base + 2 * LEN, 3000);
`else
            wait_done(3000);
            check_output("random run handshakes", hs_log.size() - base, LEN);
`endif
        end

        // Stale ack: high before presentation, must drop once first
        auto_ack = 1'b0;
        pulse_stage_reset();
        bus.update_object_position = 1'b1;
        pulse_start();
        wait_sync_low(300);
        repeat (3) begin
            @(posedge clk); #1;
            check_output("stale ack ignored", bus.sync_object_position, 0);
        end
        apply_stimulus();
        bus.update_object_position = 1'b0;
        apply_stimulus();
        bus.update_object_position = 1'b1;
        @(posedge clk); #1;
        check_output("fresh ack honoured", bus.sync_object_position, 1);
        apply_stimulus();
        bus.update_object_position = 1'b0;

        // Stage restart in the middle of PRESENT
        wait_sync_low(300);
        apply_stimulus();
        is_reset_stage = 1'b1;
        @(posedge clk); #1;
        check_output("stage reset sync", bus.sync_object_position, 1);
        check_output("stage reset busy", stream_busy, 0);
        check_output("stage reset addr", pattern_addr, 0);
        check_output("stage reset x", bus.object_pos_x, 0);
        check_output("stage reset trig", bus.object_destroy_trigger, 0);
        apply_stimulus();
        is_reset_stage = 1'b0;
        base = hs_log.size();
        auto_ack = 1'b1;
        repeat (30) apply_stimulus();
        check_output("no handshake after stage reset", hs_log.size(), base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
